button_conditioner: RTL

// - Front-panel button conditioner between raw active-low pins and POPtimers / n_state_machine.
// - Synchronises each button to clk_2M5 and debounces it on the 100us debounce_pulse tick.
// - Emits active-high debounced levels and one-cycle press strobes.
// - Masked buttons auto-repeat while held, e.g. pieovertwo_plus held = continuous stepping.

---
 rtl/button_conditioner_pkg.sv | 20 ++
 rtl/button_conditioner_debounce_cell.sv | 86 ++++++++
 rtl/button_conditioner.sv | 78 +++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the front-panel button conditioner.
// Holds the default tick counts and the button index map used by the
// conditioner and by anything that consumes its per-button outputs.
package button_conditioner_pkg;

  localparam int N_BUTTONS_DEF      = 6;
  localparam int DEBOUNCE_TICKS_DEF = 4;     // 100us ticks to accept a new level
  localparam int REPEAT_DELAY_DEF   = 5000;  // 500 ms to first auto-repeat
  localparam int REPEAT_RATE_DEF    = 1000;  // 100 ms between later repeats

  localparam logic [N_BUTTONS_DEF-1:0] REPEAT_MASK_DEF = 6'b111100;

  localparam int BTN_MODE = 0;
  localparam int BTN_LOAD = 1;
  localparam int BTN_TL   = 2;
  localparam int BTN_TR   = 3;
  localparam int BTN_BL   = 4;
  localparam int BTN_BR   = 5;

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// One button's debounce and auto-repeat state.
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   tick_en        one-cycle debounce tick, shared by all cells
//   sample         synchronised button state, 1 = pressed
//   level          debounced state, 1 = pressed
//   press          one-cycle strobe on debounced press and on each repeat
//   release_pulse  one-cycle strobe on debounced release
module button_debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE    = REPEAT_RATE_DEF,
  parameter bit REPEAT_EN      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  input  logic sample,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RP_W = $clog2(REPEAT_DELAY + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [DB_W-1:0] db_cnt;
  logic [RP_W-1:0] rp_cnt;
  logic            level_q;
  logic            rep_hit;
  logic            flip;

  // Level changes on this tick; a repeat must not fire on the tick that
  // releases the button.
  assign flip = tick_en && (sample != level) && (db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt        <= '0;
      rp_cnt        <= '0;
      level         <= 1'b0;
      level_q       <= 1'b0;
      rep_hit       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      if (tick_en) begin
        if (sample == level) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          level  <= sample;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end

      // The counter stops one short of the delay and reloads, so it never
      // holds REPEAT_DELAY and cannot wrap.  rep_hit is delayed by one cycle
      // so repeats share the latency of the initial press strobe.
      rep_hit <= 1'b0;
      if (!REPEAT_EN || !level) begin
        rp_cnt <= '0;
      end else if (tick_en && !flip) begin
        if (rp_cnt == RP_LAST) begin
          rp_cnt  <= RP_RELOAD;
          rep_hit <= 1'b1;
        end else begin
          rp_cnt <= rp_cnt + 1'b1;
        end
      end

      level_q       <= level;
      press         <= (level & ~level_q) | rep_hit;
      release_pulse <= ~level & level_q;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: synchronises raw active-low buttons,
// debounces them on the 100us tick and produces levels plus press/release
// strobes, with auto-repeat on masked buttons.
// Ports:
//   clk_2M5         2.5 MHz system clock
//   reset           synchronous, active-high
//   debounce_pulse  100us tick level from slow_clock_pulse (not a clock)
//   buttons_n       raw pins, active-low, asynchronous
//   level           debounced state, 1 = pressed
//   press           one-cycle strobe on press and on each auto-repeat
//   release_pulse   one-cycle strobe on release ("release" is a reserved word)
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BUTTONS      = N_BUTTONS_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE    = REPEAT_RATE_DEF,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK = N_BUTTONS'(REPEAT_MASK_DEF)
) (
  input  logic                 clk_2M5,
  input  logic                 reset,
  input  logic                 debounce_pulse,
  input  logic [N_BUTTONS-1:0] buttons_n,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] press,
  output logic [N_BUTTONS-1:0] release_pulse
);

  logic [N_BUTTONS-1:0] btn_s1;
  logic [N_BUTTONS-1:0] btn_s2;
  logic [N_BUTTONS-1:0] sample;
  logic                 dp_s1;
  logic                 dp_s2;
  logic                 dp_s3;
  logic                 tick_en;

  // Synchronisers reset to the released state so a held button has to
  // re-debounce after reset.  tick_en is registered, giving a fixed
  // three-cycle latency from a debounce_pulse rising edge.
  always_ff @(posedge clk_2M5) begin
    if (reset) begin
      btn_s1  <= '1;
      btn_s2  <= '1;
      dp_s1   <= 1'b0;
      dp_s2   <= 1'b0;
      dp_s3   <= 1'b0;
      tick_en <= 1'b0;
    end else begin
      btn_s1  <= buttons_n;
      btn_s2  <= btn_s1;
      dp_s1   <= debounce_pulse;
      dp_s2   <= dp_s1;
      dp_s3   <= dp_s2;
      tick_en <= dp_s2 & ~dp_s3;
    end
  end

  assign sample = ~btn_s2;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_cell
    button_debounce_cell #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_cell (
      .clk           (clk_2M5),
      .reset         (reset),
      .tick_en       (tick_en),
      .sample        (sample[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule
